// File: rtl/lwram_pkg.sv
// lwram_pkg: shared definitions for the LWRAM responder.
//   lwram_state_e  : controller states (IDLE, BUSY, DONE)
//   LWRAM_ERR_DATA : read data presented after a timed-out access
//   LWRAM_ADDR_W   : default word-address width (A[19:1], 512K x 16)
package lwram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lwram_state_e;

    localparam logic [15:0] LWRAM_ERR_DATA = 16'hFFFF;
    localparam int          LWRAM_ADDR_W   = 19;

endpackage

// File: rtl/lwram_rdcache.sv
// lwram_rdcache: one-entry read cache for the LWRAM responder.
// Only built when LWRAM_RDCACHE_EN is defined.
// Ports:
//   CLK, RST_N        : clock, async active-low reset (clears tag, data, valid)
//   lookup_addr       : address compared against the tag -> hit / hit_data
//   fill_en/addr/data : load the entry after a read miss completes
//   merge_en/addr/be/data : write-through byte merge when the address matches
//   inval             : drop the entry (timed-out access)
module lwram_rdcache
    import lwram_pkg::*;
#(
    parameter int ADDR_W = LWRAM_ADDR_W
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              hit,
    output logic [15:0]       hit_data,
    input  logic              fill_en,
    input  logic [ADDR_W-1:0] fill_addr,
    input  logic [15:0]       fill_data,
    input  logic              merge_en,
    input  logic [ADDR_W-1:0] merge_addr,
    input  logic [1:0]        merge_be,
    input  logic [15:0]       merge_data,
    input  logic              inval
);

    logic              valid;
    logic [ADDR_W-1:0] tag;
    logic [15:0]       data;

    assign hit      = valid && (tag == lookup_addr);
    assign hit_data = data;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            valid <= 1'b0;
            tag   <= '0;
            data  <= '0;
        end else if (inval) begin
            valid <= 1'b0;
        end else if (fill_en) begin
            valid <= 1'b1;
            tag   <= fill_addr;
            data  <= fill_data;
        end else if (merge_en && valid && (tag == merge_addr)) begin
            if (merge_be[1]) data[15:8] <= merge_data[15:8];
            if (merge_be[0]) data[7:0]  <= merge_data[7:0];
        end
    end

endmodule

// File: rtl/lwram_ctrl.sv
// lwram_ctrl: LWRAM bus responder. Turns DCE_N/DOE_N/DWE_N bus accesses into
// single-word req/ack transactions on the memory port and stalls the bus
// through WAIT_N until the data has been delivered.
// Optional build macro: LWRAM_RDCACHE_EN adds a one-entry read cache
// (lwram_rdcache); without it every read goes to memory.
// Ports:
//   CLK, RST_N          : clock, async active-low reset
//   CE_R, CE_F          : rising/falling phase clock enables
//   A, DI, DO           : bus word address, write data, read data
//   DCE_N, DOE_N, DWE_N : chip enable, read strobe, byte write strobes
//   WAIT_N              : bus stall (low = wait)
//   MEM_*               : memory request port (level REQ, one-CLK ACK)
//   ERR                 : sticky timeout flag
//
// state | meaning
// IDLE  | waiting for a read/write strobe edge
// BUSY  | MEM_REQ raised, waiting for MEM_ACK or timeout
// DONE  | data delivered, waiting for the bus strobes to release
module lwram_ctrl
    import lwram_pkg::*;
#(
    parameter int ADDR_W  = LWRAM_ADDR_W,
    parameter int TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              CE_R,
    input  logic              CE_F,
    input  logic [ADDR_W-1:0] A,
    input  logic [15:0]       DI,
    output logic [15:0]       DO,
    input  logic              DCE_N,
    input  logic              DOE_N,
    input  logic [1:0]        DWE_N,
    output logic              WAIT_N,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [15:0]       MEM_WDATA,
    output logic [1:0]        MEM_BE,
    output logic              MEM_WE,
    output logic              MEM_REQ,
    input  logic              MEM_ACK,
    input  logic [15:0]       MEM_RDATA,
    output logic              ERR
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    lwram_state_e     state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             doe_n_q, dwe_all_q;
    logic             rd_start, wr_start;
    logic             acc_start, acc_wr, acc_hit, ack_take, tmo, done_exit;
    logic             cache_hit;
    logic [15:0]      cache_data;

    // Strobe edges are detected against the previous CLK, not the CE phases.
    assign rd_start = !DCE_N && !DOE_N && doe_n_q;
    assign wr_start = !DCE_N && (|(~DWE_N)) && dwe_all_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        acc_start = 1'b0;
        acc_wr    = 1'b0;
        acc_hit   = 1'b0;
        ack_take  = 1'b0;
        tmo       = 1'b0;
        done_exit = 1'b0;
        case (state)
            IDLE: begin
                if (wr_start) begin
                    acc_start = 1'b1;
                    acc_wr    = 1'b1;
                    state_nxt = BUSY;
                end else if (rd_start) begin
                    acc_start = 1'b1;
                    if (cache_hit) begin
                        acc_hit   = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        state_nxt = BUSY;
                    end
                end
            end
            BUSY: begin
                if (MEM_ACK) begin
                    ack_take  = 1'b1;
                    state_nxt = DONE;
                end else if (CE_R && (cnt == CNT_W'(TIMEOUT - 1))) begin
                    tmo       = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (DOE_N && (&DWE_N)) begin
                    done_exit = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            DO        <= '0;
            WAIT_N    <= 1'b1;
            MEM_REQ   <= 1'b0;
            MEM_WE    <= 1'b0;
            MEM_BE    <= 2'b00;
            MEM_ADDR  <= '0;
            MEM_WDATA <= '0;
            ERR       <= 1'b0;
            cnt       <= '0;
            doe_n_q   <= 1'b1;
            dwe_all_q <= 1'b1;
        end else begin
            doe_n_q   <= DOE_N;
            dwe_all_q <= &DWE_N;

            // A strobe released before the first CE_F in DONE still leaves
            // WAIT_N low, so the release also applies in IDLE; a new start
            // below overrides it.
            if ((state != BUSY) && CE_F) WAIT_N <= 1'b1;

            if (acc_start) begin
                MEM_ADDR  <= A;
                MEM_WDATA <= DI;
                MEM_BE    <= acc_wr ? ~DWE_N : 2'b11;
                MEM_WE    <= acc_wr;
                if (acc_hit) begin
                    DO <= cache_data;
                end else begin
                    MEM_REQ <= 1'b1;
                    WAIT_N  <= 1'b0;
                end
            end

            if ((state == BUSY) && CE_R && !ack_take) cnt <= cnt + 1'b1;

            if (ack_take) begin
                MEM_REQ <= 1'b0;
                if (!MEM_WE) DO <= MEM_RDATA;
            end

            if (tmo) begin
                MEM_REQ <= 1'b0;
                DO      <= LWRAM_ERR_DATA;
                ERR     <= 1'b1;
            end

            if (done_exit) cnt <= '0;
        end
    end

`ifdef LWRAM_RDCACHE_EN
    lwram_rdcache #(.ADDR_W(ADDR_W)) u_rdcache (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .lookup_addr(A),
        .hit        (cache_hit),
        .hit_data   (cache_data),
        .fill_en    (ack_take && !MEM_WE),
        .fill_addr  (MEM_ADDR),
        .fill_data  (MEM_RDATA),
        .merge_en   (acc_start && acc_wr),
        .merge_addr (A),
        .merge_be   (~DWE_N),
        .merge_data (DI),
        .inval      (tmo)
    );
`else
    assign cache_hit  = 1'b0;
    assign cache_data = 16'h0000;
`endif

endmodule

// File: tb/tb_lwram_ctrl.sv
// tb_lwram_ctrl: directed bench for lwram_ctrl. A vector table covers
// reads, byte writes, read/write collision and strobe release during BUSY;
// hand-written sequences cover async reset in BUSY, the timeout path and
// (when LWRAM_RDCACHE_EN is defined) the read cache.
module tb_lwram_ctrl;

    localparam int AW = 19;

    logic          CLK, RST_N, CE_R, CE_F;
    logic [AW-1:0] A;
    logic [15:0]   DI, DO;
    logic          DCE_N, DOE_N;
    logic [1:0]    DWE_N;
    logic          WAIT_N;
    logic [AW-1:0] MEM_ADDR;
    logic [15:0]   MEM_WDATA;
    logic [1:0]    MEM_BE;
    logic          MEM_WE, MEM_REQ, MEM_ACK;
    logic [15:0]   MEM_RDATA;
    logic          ERR;

    int checks = 0;
    int errors = 0;

    lwram_ctrl #(.ADDR_W(AW), .TIMEOUT(255)) dut (
        .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .CE_F(CE_F),
        .A(A), .DI(DI), .DO(DO),
        .DCE_N(DCE_N), .DOE_N(DOE_N), .DWE_N(DWE_N), .WAIT_N(WAIT_N),
        .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_BE(MEM_BE),
        .MEM_WE(MEM_WE), .MEM_REQ(MEM_REQ), .MEM_ACK(MEM_ACK),
        .MEM_RDATA(MEM_RDATA), .ERR(ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic          ce_r, ce_f;
        logic [AW-1:0] a;
        logic [15:0]   di;
        logic          dce_n, doe_n;
        logic [1:0]    dwe_n;
        logic          ack;
        logic [15:0]   rdata;
        logic [56:0]   exp;
    } vec_t;

    vec_t vt[$];

    // {DO, WAIT_N, MEM_REQ, MEM_WE, MEM_BE, MEM_ADDR, MEM_WDATA, ERR}
    function automatic logic [56:0] pack(input logic [15:0] d, input logic w, input logic rq,
                                         input logic we, input logic [1:0] be,
                                         input logic [AW-1:0] ad, input logic [15:0] wd,
                                         input logic er);
        return {d, w, rq, we, be, ad, wd, er};
    endfunction

    function automatic logic [56:0] out_vec();
        return {DO, WAIT_N, MEM_REQ, MEM_WE, MEM_BE, MEM_ADDR, MEM_WDATA, ERR};
    endfunction

    localparam logic [56:0] RST_VEC = {16'h0000, 1'b1, 1'b0, 1'b0, 2'b00, 19'h0, 16'h0000, 1'b0};

    task automatic add(input logic ce_r, input logic ce_f, input logic [AW-1:0] a,
                       input logic [15:0] di, input logic dce_n, input logic doe_n,
                       input logic [1:0] dwe_n, input logic ack, input logic [15:0] rdata,
                       input logic [15:0] e_do, input logic e_w, input logic e_rq,
                       input logic e_we, input logic [1:0] e_be, input logic [AW-1:0] e_ad,
                       input logic [15:0] e_wd, input logic e_er);
        vec_t v;
        v.ce_r = ce_r; v.ce_f = ce_f; v.a = a; v.di = di;
        v.dce_n = dce_n; v.doe_n = doe_n; v.dwe_n = dwe_n;
        v.ack = ack; v.rdata = rdata;
        v.exp = pack(e_do, e_w, e_rq, e_we, e_be, e_ad, e_wd, e_er);
        vt.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK);
    endtask

    task automatic drive(input logic dce_n, input logic doe_n, input logic [1:0] dwe_n,
                         input logic [AW-1:0] a, input logic [15:0] di);
        DCE_N = dce_n; DOE_N = doe_n; DWE_N = dwe_n; A = a; DI = di;
    endtask

    // Release strobes with a CE_F so DONE exits and WAIT_N is high again.
    task automatic finish_access();
        DCE_N = 1'b1; DOE_N = 1'b1; DWE_N = 2'b11; CE_F = 1'b1;
        step();
        CE_F = 1'b0;
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    initial begin
        RST_N = 1'b0; CE_R = 1'b0; CE_F = 1'b0;
        drive(1'b1, 1'b1, 2'b11, '0, '0);
        MEM_ACK = 1'b0; MEM_RDATA = '0;

        // ce_r ce_f a di dce doe dwe ack rdata | DO W REQ WE BE ADDR WDATA ERR
        add(0,0,0,0,1,1,3,0,0,             16'h0000,1,0,0,0,0,0,0);
        // read of 0x10, ack after 6 CLK
        add(0,0,'h10,0,0,0,3,0,0,          16'h0000,0,1,0,3,'h10,0,0);
        add(0,0,'h10,0,0,0,3,0,0,          16'h0000,0,1,0,3,'h10,0,0);
        add(0,0,'h10,0,0,0,3,0,0,          16'h0000,0,1,0,3,'h10,0,0);
        add(0,1,'h10,0,0,0,3,0,0,          16'h0000,0,1,0,3,'h10,0,0);
        add(1,0,'h10,0,0,0,3,0,0,          16'h0000,0,1,0,3,'h10,0,0);
        add(0,0,'h10,0,0,0,3,0,0,          16'h0000,0,1,0,3,'h10,0,0);
        add(0,0,'h10,0,0,0,3,1,'hBEEF,     16'hBEEF,0,0,0,3,'h10,0,0);
        add(0,0,'h10,0,0,0,3,0,0,          16'hBEEF,0,0,0,3,'h10,0,0);
        add(0,1,'h10,0,0,0,3,0,0,          16'hBEEF,1,0,0,3,'h10,0,0);
        add(0,0,'h10,0,0,0,3,1,'h1234,     16'hBEEF,1,0,0,3,'h10,0,0);
        add(0,0,'h10,0,1,1,3,0,0,          16'hBEEF,1,0,0,3,'h10,0,0);
        add(0,0,0,0,1,1,3,1,'h5678,        16'hBEEF,1,0,0,3,'h10,0,0);
        // upper-byte write at the top address
        add(0,0,'h7FFFF,'h12AB,0,1,1,0,0,  16'hBEEF,0,1,1,2,'h7FFFF,'h12AB,0);
        add(0,0,'h7FFFF,'h12AB,0,1,1,1,'h9999, 16'hBEEF,0,0,1,2,'h7FFFF,'h12AB,0);
        add(0,1,'h7FFFF,'h12AB,0,1,1,0,0,  16'hBEEF,1,0,1,2,'h7FFFF,'h12AB,0);
        add(0,0,'h7FFFF,'h12AB,1,1,3,0,0,  16'hBEEF,1,0,1,2,'h7FFFF,'h12AB,0);
        // read and word write on the same CLK: write wins
        add(0,0,'h20,'hA5A5,0,0,0,0,0,     16'hBEEF,0,1,1,3,'h20,'hA5A5,0);
        add(0,0,'h20,'hA5A5,0,0,0,1,'h0F0F,16'hBEEF,0,0,1,3,'h20,'hA5A5,0);
        add(0,1,'h20,'hA5A5,1,1,3,0,0,     16'hBEEF,1,0,1,3,'h20,'hA5A5,0);
        add(0,0,'h20,'hA5A5,1,1,3,0,0,     16'hBEEF,1,0,1,3,'h20,'hA5A5,0);
        // strobe released while BUSY; DONE exits before any CE_F
        add(0,0,'h30,0,0,0,3,0,0,          16'hBEEF,0,1,0,3,'h30,0,0);
        add(0,0,'h30,0,1,1,3,0,0,          16'hBEEF,0,1,0,3,'h30,0,0);
        add(0,0,'h30,0,1,1,3,1,'hC3C3,     16'hC3C3,0,0,0,3,'h30,0,0);
        add(0,0,'h30,0,1,1,3,0,0,          16'hC3C3,0,0,0,3,'h30,0,0);
        add(0,1,'h30,0,1,1,3,0,0,          16'hC3C3,1,0,0,3,'h30,0,0);

        step();
        chk("reset_state", out_vec(), RST_VEC);
        RST_N = 1'b1;

        for (int i = 0; i < vt.size(); i++) begin
            CE_R = vt[i].ce_r; CE_F = vt[i].ce_f;
            drive(vt[i].dce_n, vt[i].doe_n, vt[i].dwe_n, vt[i].a, vt[i].di);
            MEM_ACK = vt[i].ack; MEM_RDATA = vt[i].rdata;
            step();
            chk($sformatf("vec%0d", i), out_vec(), vt[i].exp);
        end
        CE_R = 1'b0; CE_F = 1'b0; MEM_ACK = 1'b0;

        // async reset while BUSY, then a late ACK must be ignored
        drive(1'b0, 1'b0, 2'b11, 19'h00040, 16'h0);
        step();
        chk("rst_busy_req", MEM_REQ, 1'b1);
        RST_N = 1'b0;
        #1;
        chk("rst_async", out_vec(), RST_VEC);
        drive(1'b1, 1'b1, 2'b11, 19'h00040, 16'h0);
        step();
        RST_N = 1'b1; MEM_ACK = 1'b1; MEM_RDATA = 16'h7777;
        step();
        MEM_ACK = 1'b0;
        chk("rst_ack_ignored", out_vec(), RST_VEC);
        step();
        chk("rst_ack_idle", out_vec(), RST_VEC);

        // timeout: 255 CE_R ticks without ACK
        drive(1'b0, 1'b0, 2'b11, 19'h00050, 16'h0);
        step();
        chk("tmo_start", {MEM_REQ, WAIT_N, ERR}, 3'b100);
        CE_R = 1'b1;
        repeat (254) step();
        chk("tmo_254_ticks", {MEM_REQ, ERR}, 2'b10);
        step();
        CE_R = 1'b0;
        chk("tmo_255_ticks", {MEM_REQ, ERR, WAIT_N, DO}, {1'b0, 1'b1, 1'b0, 16'hFFFF});
        CE_F = 1'b1;
        step();
        CE_F = 1'b0;
        chk("tmo_wait_release", WAIT_N, 1'b1);
        finish_access();
        drive(1'b0, 1'b0, 2'b11, 19'h00060, 16'h0);
        step();
        chk("post_tmo_req", MEM_REQ, 1'b1);
        MEM_ACK = 1'b1; MEM_RDATA = 16'h1357;
        step();
        MEM_ACK = 1'b0;
        chk("post_tmo_read", {DO, ERR}, {16'h1357, 1'b1});
        finish_access();

`ifdef LWRAM_RDCACHE_EN
        drive(1'b0, 1'b0, 2'b11, 19'h00100, 16'h0);
        step();
        chk("c_miss_req", MEM_REQ, 1'b1);
        MEM_ACK = 1'b1; MEM_RDATA = 16'h5555;
        step();
        MEM_ACK = 1'b0;
        chk("c_miss_do", DO, 16'h5555);
        finish_access();
        drive(1'b0, 1'b0, 2'b11, 19'h00100, 16'h0);
        step();
        chk("c_hit", {MEM_REQ, WAIT_N, DO}, {1'b0, 1'b1, 16'h5555});
        step();
        chk("c_hit_hold", {MEM_REQ, WAIT_N, DO}, {1'b0, 1'b1, 16'h5555});
        finish_access();
        drive(1'b0, 1'b1, 2'b10, 19'h00100, 16'h00AA);
        step();
        chk("c_wr", {MEM_REQ, MEM_WE, MEM_BE, MEM_WDATA}, {1'b1, 1'b1, 2'b01, 16'h00AA});
        MEM_ACK = 1'b1;
        step();
        MEM_ACK = 1'b0;
        finish_access();
        drive(1'b0, 1'b0, 2'b11, 19'h00100, 16'h0);
        step();
        chk("c_merge", {MEM_REQ, WAIT_N, DO}, {1'b0, 1'b1, 16'h55AA});
        finish_access();
`else
        drive(1'b0, 1'b0, 2'b11, 19'h00100, 16'h0);
        step();
        MEM_ACK = 1'b1; MEM_RDATA = 16'h5555;
        step();
        MEM_ACK = 1'b0;
        chk("nc_first_do", DO, 16'h5555);
        finish_access();
        drive(1'b0, 1'b0, 2'b11, 19'h00100, 16'h0);
        step();
        chk("nc_reread_req", {MEM_REQ, WAIT_N}, 2'b10);
        MEM_ACK = 1'b1; MEM_RDATA = 16'h6666;
        step();
        MEM_ACK = 1'b0;
        chk("nc_reread_do", DO, 16'h6666);
        finish_access();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
